dt_skeleton_scan: RTL and testbench

- Downstream consumer of the distance-transform result RAM: a 128x128 image, 8-bit per pixel, addressed {y[6:0],x[6:0]}.
- Starts when the DT stage asserts done. Scans the distance map and marks local-maximum (medial-axis) pixels.
- Writes the skeleton as a packed binary image into a 1024x16 skeleton RAM, using the same bit packing as the stimulus ROM.
- Reports skeleton pixel count, maximum skeleton distance and its address.

---
 rtl/dt_skeleton_scan.sv | 211 +++++++++++++++++++++
 tb/tb_dt_skeleton_scan.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dt_skeleton_scan.sv
// Skeleton scan: marks local maxima of the DT map into a packed binary RAM.
// Define SKEL_8NB_EN to compare against 8 neighbours instead of 4.
module dt_skeleton_scan #(
  parameter int MIN_DIST = 1,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          res_rd,
  output logic [13:0]   res_addr,
  input  logic [DW-1:0] res_di,
  output logic          sk_wr,
  output logic [9:0]    sk_addr,
  output logic [15:0]   sk_do,
  output logic          done,
  output logic [13:0]   sk_count,
  output logic [DW-1:0] max_val,
  output logic [13:0]   max_addr
);

`ifdef SKEL_8NB_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif

  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam logic [DW-1:0] MIN_D    = DW'(MIN_DIST);
  localparam logic [13:0]   PIX_LAST = 14'h3FFF;
  localparam logic [13:0]   CNT_MAX  = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_C,
    S_RD_NB,
    S_NEXT,
    S_WR,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   pix_q, pix_d;
  logic [15:0]   word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] center_q, center_d;
  logic          mark_q, mark_d;
  logic [13:0]   sk_count_q, sk_count_d;
  logic [DW-1:0] max_val_q, max_val_d;
  logic [13:0]   max_addr_q, max_addr_d;

  logic [6:0] px;
  logic [6:0] py;
  logic       border;
  logic       go;

  // Signed offsets in 14-bit two's complement; border exclusion keeps
  // every neighbour address inside the image.
  function automatic logic [13:0] nb_off(input logic [CW-1:0] c);
    nb_off = '0;
`ifdef SKEL_8NB_EN
    unique case (c)
      3'd0: nb_off = 14'h3F7F;
      3'd1: nb_off = 14'h3F80;
      3'd2: nb_off = 14'h3F81;
      3'd3: nb_off = 14'h3FFF;
      3'd4: nb_off = 14'h0001;
      3'd5: nb_off = 14'h007F;
      3'd6: nb_off = 14'h0080;
      3'd7: nb_off = 14'h0081;
      default: nb_off = '0;
    endcase
`else
    unique case (c)
      2'd0: nb_off = 14'h3F80;
      2'd1: nb_off = 14'h3FFF;
      2'd2: nb_off = 14'h0001;
      2'd3: nb_off = 14'h0080;
      default: nb_off = '0;
    endcase
`endif
  endfunction

  assign px     = pix_q[6:0];
  assign py     = pix_q[13:7];
  assign border = (px == 7'd0) || (px == 7'h7F) ||
                  (py == 7'd0) || (py == 7'h7F);
  assign go     = start &&
                  ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    center_d   = center_q;
    mark_d     = mark_q;
    sk_count_d = sk_count_q;
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    res_rd     = 1'b0;
    res_addr   = '0;
    sk_wr      = 1'b0;
    sk_addr    = '0;
    sk_do      = '0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_RD_C: begin
        if (border) begin
          mark_d  = 1'b0;
          state_d = S_NEXT;
        end else begin
          res_rd   = 1'b1;
          res_addr = pix_q;
          if (res_di < MIN_D) begin
            mark_d  = 1'b0;
            state_d = S_NEXT;
          end else begin
            center_d = res_di;
            cnt_d    = '0;
            state_d  = S_RD_NB;
          end
        end
      end
      S_RD_NB: begin
        res_rd   = 1'b1;
        res_addr = pix_q + nb_off(cnt_q);
        if (res_di > center_q) begin
          mark_d  = 1'b0;
          state_d = S_NEXT;
        end else if (cnt_q == CNT_LAST) begin
          mark_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        word_d = {word_q[14:0], mark_q};
        if (mark_q) begin
          if (sk_count_q != CNT_MAX)
            sk_count_d = sk_count_q + 14'd1;
          // strict compare keeps the first maximum in raster order
          if (center_q > max_val_q) begin
            max_val_d  = center_q;
            max_addr_d = pix_q;
          end
        end
        if (pix_q[3:0] == 4'hF) begin
          state_d = S_WR;
        end else begin
          pix_d   = pix_q + 14'd1;
          state_d = S_RD_C;
        end
      end
      S_WR: begin
        sk_wr   = 1'b1;
        sk_addr = pix_q[13:4];
        sk_do   = word_q;
        if (pix_q == PIX_LAST) begin
          state_d = S_DONE;
        end else begin
          pix_d   = pix_q + 14'd1;
          state_d = S_RD_C;
        end
      end
      S_DONE: done = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      pix_d      = '0;
      word_d     = '0;
      sk_count_d = '0;
      max_val_d  = '0;
      max_addr_d = '0;
      state_d    = S_RD_C;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      center_q   <= '0;
      mark_q     <= 1'b0;
      sk_count_q <= '0;
      max_val_q  <= '0;
      max_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      center_q   <= center_d;
      mark_q     <= mark_d;
      sk_count_q <= sk_count_d;
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
    end
  end

  assign sk_count = sk_count_q;
  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;

endmodule

// File: tb/tb_dt_skeleton_scan.sv
// Bench for dt_skeleton_scan: reference local-maximum model feeds a
// scoreboard of expected skeleton words.
module tb_dt_skeleton_scan;

  localparam int DW = 8;
  localparam int MIN_DIST = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          res_rd;
  logic [13:0]   res_addr;
  logic [DW-1:0] res_di;
  logic          sk_wr;
  logic [9:0]    sk_addr;
  logic [15:0]   sk_do;
  logic          done;
  logic [13:0]   sk_count;
  logic [DW-1:0] max_val;
  logic [13:0]   max_addr;

  logic [DW-1:0] mem [16384];

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int exp_count;
  int exp_max;
  int exp_maddr;

  always #5 clk = ~clk;

  assign res_di = mem[res_addr];

  dt_skeleton_scan #(.MIN_DIST(MIN_DIST), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .res_rd(res_rd),
    .res_addr(res_addr),
    .res_di(res_di),
    .sk_wr(sk_wr),
    .sk_addr(sk_addr),
    .sk_do(sk_do),
    .done(done),
    .sk_count(sk_count),
    .max_val(max_val),
    .max_addr(max_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_marked(input int p);
    int x, y, v;
    x = p % 128;
    y = p / 128;
    v = int'(mem[p]);
    if (x == 0 || x == 127 || y == 0 || y == 127) return 1'b0;
    if (v < MIN_DIST) return 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        bit use_it;
`ifdef SKEL_8NB_EN
        use_it = !(dx == 0 && dy == 0);
`else
        use_it = (dx == 0) != (dy == 0);
`endif
        if (use_it && int'(mem[(y + dy) * 128 + x + dx]) > v)
          return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic build_expect();
    exp_t e;
    sb.delete();
    exp_count = 0;
    exp_max   = 0;
    exp_maddr = 0;
    for (int w = 0; w < 1024; w++) begin
      e.addr = 10'(w);
      e.data = '0;
      for (int b = 0; b < 16; b++) begin
        int p;
        p = w * 16 + b;
        if (is_marked(p)) begin
          e.data[15 - b] = 1'b1;
          exp_count++;
          if (int'(mem[p]) > exp_max) begin
            exp_max   = int'(mem[p]);
            exp_maddr = p;
          end
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, 32'(sk_count), 32'(exp_count));
    chk({tag, "_max"}, 32'(max_val), 32'(exp_max));
    chk({tag, "_maddr"}, 32'(max_addr), 32'(exp_maddr));
    chk({tag, "_wrs"}, 32'(wr_cnt), 32'd1024);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!res_rd) chk("res_addr_idle", 32'(res_addr), 32'd0);
      if (sk_wr) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sk_addr", 32'(sk_addr), 32'(e.addr));
          chk("sk_do", 32'(sk_do), 32'(e.data));
        end
        wr_cnt++;
      end else begin
        chk("sk_idle", {6'd0, sk_addr, sk_do}, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_rd", 32'(res_rd), 32'd0);
    chk("rst_sk_wr", 32'(sk_wr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(sk_count), 32'd0);
    chk("rst_max", 32'(max_val), 32'd0);
    chk("rst_maddr", 32'(max_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_done", 32'(done), 32'd0);

    // all-zero image, with a stray start mid-scan
    build_expect();
    wr_cnt = 0;
    pulse_start();
    repeat (200) @(posedge clk);
    #1;
    pulse_start();
    wait_done(40000);
    check_results("zero");
    repeat (5) @(posedge clk);
    #1;
    chk("zero_hold_done", 32'(done), 32'd1);
    chk("zero_hold_count", 32'(sk_count), 32'd0);

    // single pixel, square, two peaks, plateau in one image
    mem[645] = 8'd1;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        int ay, ax, m;
        ay = dy < 0 ? -dy : dy;
        ax = dx < 0 ? -dx : dx;
        m = ay > ax ? ay : ax;
        mem[(10 + dy) * 128 + 10 + dx] = DW'(3 - m);
      end
    end
    mem[300] = 8'd4;
    mem[900] = 8'd4;
    mem[30 * 128 + 20] = 8'd2;
    mem[30 * 128 + 21] = 8'd2;

    build_expect();
    chk("model_max", 32'(exp_max), 32'd4);
    chk("model_maddr", 32'(exp_maddr), 32'd300);
    wr_cnt = 0;
    pulse_start();
    chk("restart_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 5000 && wr_cnt < 50; i++) @(posedge clk);
    chk("mid_wr50", 32'(wr_cnt >= 50), 32'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_res_rd", 32'(res_rd), 32'd0);
    chk("mid_rst_sk_wr", 32'(sk_wr), 32'd0);
    chk("mid_rst_count", 32'(sk_count), 32'd0);
    chk("mid_rst_max", 32'(max_val), 32'd0);
    chk("mid_rst_maddr", 32'(max_addr), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    build_expect();
    wr_cnt = 0;
    pulse_start();
    wait_done(40000);
    check_results("mix");
    chk("mix_max_const", 32'(max_val), 32'd4);
    chk("mix_maddr_const", 32'(max_addr), 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
